// File: rtl/muldiv_hilo_if.sv
// Handshake and HI/LO bus between the EX stage and the multiply/divide unit.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             annul_i;
    logic             busy_o;
    logic             done_o;
    logic             div_by_zero_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, annul_i,
        input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, annul_i,
        output busy_o, done_o, div_by_zero_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair for the EX stage.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here in the accept edge
// SETUP | divide: replace captured operands by their magnitudes
// ITER  | one multiply (shift-add) or divide (restoring) step per cycle
// WRITE | sign fix-up, commit HI/LO, pulse done
module muldiv_hilo_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input logic          clk,
    input logic          rst,
    muldiv_hilo_if.slave bus
);
    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {IDLE, SETUP, ITER, WRITE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    // Product accumulator for multiplies; {remainder, quotient} for divides.
    logic [2*WIDTH-1:0] acc_q;
    // Multiplicand magnitude, or divisor (raw until SETUP, then magnitude).
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;      // result / quotient must be negated
    logic               rem_neg_q;  // dividend was negative
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_out_q;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] fast_prod_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step_d;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_step_d;
    logic               is_div_q;
    logic [WIDTH-1:0]   dvd_mag_d;
    logic [WIDTH-1:0]   dvs_mag_d;
    logic [2*WIDTH-1:0] prod_res_d;
    logic [WIDTH-1:0]   quo_fix_d;
    logic [WIDTH-1:0]   rem_fix_d;
    logic [2*WIDTH-1:0] hilo_d;

    assign signed_op = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV) ||
                       (bus.op_i == OP_MADD) || (bus.op_i == OP_MSUB);
    assign a_neg     = signed_op & bus.a_i[WIDTH-1];
    assign b_neg     = signed_op & bus.b_i[WIDTH-1];
    assign a_abs     = a_neg ? -bus.a_i : bus.a_i;
    assign b_abs     = b_neg ? -bus.b_i : bus.b_i;

    // Sign- or zero-extended operands; the low 2W bits of the product are then
    // correct for both signed and unsigned interpretations.
    assign a_ext       = {{WIDTH{a_neg}}, bus.a_i};
    assign b_ext       = {{WIDTH{b_neg}}, bus.b_i};
    assign fast_prod_d = a_ext * b_ext;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step_d = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: a borrow out of bit WIDTH means the trial failed.
    assign div_trial  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    assign div_step_d = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                         : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    // Divisor sign is recovered as neg_q ^ rem_neg_q.
    assign dvd_mag_d = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign dvs_mag_d = (neg_q ^ rem_neg_q) ? -opnd_q : opnd_q;

    assign prod_res_d = neg_q ? -acc_q : acc_q;
    assign quo_fix_d  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix_d  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Value committed to {HI,LO} at the write edge; old HI/LO is read here.
    always_comb begin
        hilo_d = prod_res_d;
        case (op_q)
            OP_MADD: hilo_d = {hi_q, lo_q} + prod_res_d;
            OP_MSUB: hilo_d = {hi_q, lo_q} - prod_res_d;
            OP_DIV, OP_DIVU: begin
                if (dz_q) hilo_d = {acc_q[WIDTH-1:0], {WIDTH{1'b1}}};
                else      hilo_d = {rem_fix_d, quo_fix_d};
            end
            default: ;
        endcase
    end

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
            if (bus.annul_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_i) begin
                            op_q <= bus.op_i;
                            case (bus.op_i)
                                OP_MTHI: begin
                                    hi_q   <= bus.a_i;
                                    done_q <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo_q   <= bus.a_i;
                                    done_q <= 1'b1;
                                end
                                OP_DIV, OP_DIVU: begin
                                    acc_q     <= {{WIDTH{1'b0}}, bus.a_i};
                                    opnd_q    <= bus.b_i;
                                    neg_q     <= a_neg ^ b_neg;
                                    rem_neg_q <= a_neg;
                                    dz_q      <= (bus.b_i == '0);
                                    busy_q    <= 1'b1;
                                    state_q   <= (bus.b_i == '0) ? WRITE : SETUP;
                                end
                                default: begin
                                    dz_q      <= 1'b0;
                                    rem_neg_q <= 1'b0;
                                    busy_q    <= 1'b1;
                                    if (FAST_MUL) begin
                                        acc_q   <= fast_prod_d;
                                        neg_q   <= 1'b0;
                                        state_q <= WRITE;
                                    end else begin
                                        acc_q   <= {{WIDTH{1'b0}}, b_abs};
                                        opnd_q  <= a_abs;
                                        neg_q   <= a_neg ^ b_neg;
                                        cnt_q   <= ITER_LAST;
                                        state_q <= ITER;
                                    end
                                end
                            endcase
                        end
                    end
                    SETUP: begin
                        acc_q   <= {{WIDTH{1'b0}}, dvd_mag_d};
                        opnd_q  <= dvs_mag_d;
                        cnt_q   <= ITER_LAST;
                        state_q <= ITER;
                    end
                    ITER: begin
                        acc_q <= is_div_q ? div_step_d : mul_step_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) state_q <= WRITE;
                    end
                    WRITE: begin
                        {hi_q, lo_q} <= hilo_d;
                        done_q       <= 1'b1;
                        dz_out_q     <= dz_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.div_by_zero_o = dz_out_q;
    assign bus.hi_o          = hi_q;
    assign bus.lo_o          = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: a fast 32-bit instance and an
// iterative 16-bit instance. Expected HI/LO come from a behavioural model
// using native 64-bit arithmetic and are queued when each op is issued.
module tb_muldiv_hilo_unit;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    muldiv_hilo_if #(.WIDTH(32)) bus ();
    muldiv_hilo_if #(.WIDTH(16)) bus2 ();

    muldiv_hilo_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    muldiv_hilo_unit #(.WIDTH(16), .FAST_MUL(1'b0)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
    } stim_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          lat;
    int          busy_cnt;
    bit          timeout;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sbv, q, rm;
        longint unsigned ua, ub, uq, urm;
        logic [63:0]     r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        r   = '0;
        case (op)
            OP_MULT:  r = sa * sbv;
            OP_MULTU: r = ua * ub;
            OP_MADD:  r = {hi, lo} + 64'(sa * sbv);
            OP_MSUB:  r = {hi, lo} - 64'(sa * sbv);
            OP_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sbv;
                    rm = sa % sbv;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    uq  = ua / ub;
                    urm = ua % ub;
                    r   = {urm[31:0], uq[31:0]};
                end
            end
            OP_MTHI: r = {a, lo};
            default: r = {hi, a};
        endcase
        return r;
    endfunction

    task automatic expect_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        r    = model(op, a, b, m_hi, m_lo);
        m_hi = r[63:32];
        m_lo = r[31:0];
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = ((op == OP_DIV) || (op == OP_DIVU)) && (b == 0);
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        expect_op(op, a, b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done();
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done_o && lat < 200) begin
            if (bus.busy_o) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        timeout = !bus.done_o;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        rst2 = 1'b0;
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.hi_o !== 32'h0) $display("FAIL reset_hi got %h exp 0", bus.hi_o); else n_pass++;
        n_checks++; if (bus.lo_o !== 32'h0) $display("FAIL reset_lo got %h exp 0", bus.lo_o); else n_pass++;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.done_o !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done_o); else n_pass++;
        n_checks++; if (bus.div_by_zero_o !== 1'b0) $display("FAIL reset_dz got %b exp 0", bus.div_by_zero_o); else n_pass++;
        n_checks++; if (bus2.hi_o !== 16'h0 || bus2.lo_o !== 16'h0) $display("FAIL reset2_hilo got %h/%h exp 0/0", bus2.hi_o, bus2.lo_o); else n_pass++;
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        stim_t t[5];
        exp_t  e;
        t[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3, 1};
        t[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1};
        t[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 1};
        t[3] = '{OP_MULT,  $urandom, $urandom, 1};
        t[4] = '{OP_MULTU, $urandom, $urandom, 1};
        for (int i = 0; i < 5; i++) begin
            drive(t[i].op, t[i].a, t[i].b);
            wait_done();
            n_checks++; if (timeout || lat != t[i].lat) $display("FAIL mult_lat[%0d] got %0d exp %0d", i, lat, t[i].lat); else n_pass++;
            e = sb.pop_front();
            n_checks++; if ({bus.hi_o, bus.lo_o} !== {e.hi, e.lo}) $display("FAIL mult_hilo[%0d] got %h_%h exp %h_%h", i, bus.hi_o, bus.lo_o, e.hi, e.lo); else n_pass++;
        end
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL mult_busy_in_done got %b exp 0", bus.busy_o); else n_pass++;
    endtask

    task automatic test_div();
        stim_t t[7];
        exp_t  e;
        t[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2, 34};
        t[1] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 34};
        t[2] = '{OP_DIVU, 32'hFFFF_FFF9, 32'd2, 34};
        t[3] = '{OP_DIV,  32'd7, 32'hFFFF_FFFE, 34};
        t[4] = '{OP_DIV,  $urandom, $urandom_range(1, 1000), 34};
        t[5] = '{OP_DIVU, $urandom, $urandom, 34};
        t[6] = '{OP_DIVU, 32'd5, 32'd0, 1};
        for (int i = 0; i < 7; i++) begin
            drive(t[i].op, t[i].a, t[i].b);
            wait_done();
            n_checks++; if (timeout || lat != t[i].lat) $display("FAIL div_lat[%0d] got %0d exp %0d", i, lat, t[i].lat); else n_pass++;
            n_checks++; if (busy_cnt != t[i].lat) $display("FAIL div_busy_cycles[%0d] got %0d exp %0d", i, busy_cnt, t[i].lat); else n_pass++;
            e = sb.pop_front();
            n_checks++; if ({bus.hi_o, bus.lo_o} !== {e.hi, e.lo}) $display("FAIL div_hilo[%0d] got %h_%h exp %h_%h", i, bus.hi_o, bus.lo_o, e.hi, e.lo); else n_pass++;
            n_checks++; if (bus.div_by_zero_o !== e.dz) $display("FAIL div_dz[%0d] got %b exp %b", i, bus.div_by_zero_o, e.dz); else n_pass++;
        end
        n_checks++; if (bus.hi_o !== 32'd5 || bus.lo_o !== 32'hFFFF_FFFF) $display("FAIL divu_by_zero got %h_%h exp 00000005_ffffffff", bus.hi_o, bus.lo_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.done_o !== 1'b0 || bus.div_by_zero_o !== 1'b0) $display("FAIL dz_pulse_width got %b/%b exp 0/0", bus.done_o, bus.div_by_zero_o); else n_pass++;
    endtask

    task automatic test_madd_msub();
        stim_t t[4];
        exp_t  e;
        t[0] = '{OP_MTHI, 32'h1234_5678, 32'd0, 0};
        t[1] = '{OP_MTLO, 32'd1, 32'd0, 0};
        t[2] = '{OP_MADD, 32'd2, 32'd3, 1};
        t[3] = '{OP_MSUB, 32'd1, 32'd8, 1};
        for (int i = 0; i < 4; i++) begin
            drive(t[i].op, t[i].a, t[i].b);
            wait_done();
            n_checks++; if (timeout || lat != t[i].lat) $display("FAIL madd_lat[%0d] got %0d exp %0d", i, lat, t[i].lat); else n_pass++;
            n_checks++; if (busy_cnt != t[i].lat) $display("FAIL madd_busy[%0d] got %0d exp %0d", i, busy_cnt, t[i].lat); else n_pass++;
            e = sb.pop_front();
            n_checks++; if ({bus.hi_o, bus.lo_o} !== {e.hi, e.lo}) $display("FAIL madd_hilo[%0d] got %h_%h exp %h_%h", i, bus.hi_o, bus.lo_o, e.hi, e.lo); else n_pass++;
            if (i == 2) begin
                n_checks++; if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== 32'd7) $display("FAIL madd_value got %h_%h exp 12345678_00000007", bus.hi_o, bus.lo_o); else n_pass++;
            end
        end
        n_checks++; if (bus.hi_o !== 32'h1234_5677 || bus.lo_o !== 32'hFFFF_FFFF) $display("FAIL msub_value got %h_%h exp 12345677_ffffffff", bus.hi_o, bus.lo_o); else n_pass++;
    endtask

    task automatic test_annul();
        int   dones;
        exp_t e;
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIV;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL annul_busy got %b exp 0", bus.busy_o); else n_pass++;
        @(negedge clk);
        bus.annul_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        n_checks++; if (dones != 0) $display("FAIL annul_no_done got %0d exp 0", dones); else n_pass++;
        n_checks++; if ({bus.hi_o, bus.lo_o} !== {m_hi, m_lo}) $display("FAIL annul_hilo got %h_%h exp %h_%h", bus.hi_o, bus.lo_o, m_hi, m_lo); else n_pass++;
        // annul wins over a start on the same edge
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        bus.op_i    = OP_MTHI;
        bus.a_i     = 32'h0BAD_0BAD;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        n_checks++; if (bus.done_o !== 1'b0 || bus.hi_o !== m_hi) $display("FAIL annul_priority got done=%b hi=%h exp done=0 hi=%h", bus.done_o, bus.hi_o, m_hi); else n_pass++;
        drive(OP_DIVU, 32'd100, 32'd7);
        wait_done();
        n_checks++; if (timeout || lat != 34) $display("FAIL post_annul_lat got %0d exp 34", lat); else n_pass++;
        e = sb.pop_front();
        n_checks++; if ({bus.hi_o, bus.lo_o} !== {e.hi, e.lo} || bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) $display("FAIL post_annul_divu got %h_%h exp %h_%h", bus.hi_o, bus.lo_o, e.hi, e.lo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        expect_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0001);
        bus.start_i = 1'b1;
        bus.op_i    = OP_MULT;
        bus.a_i     = 32'h7FFF_FFFF;
        bus.b_i     = 32'h8000_0001;
        @(posedge clk);
        @(negedge clk);
        bus.op_i = OP_MTLO;  // start held high while busy: must be ignored
        bus.a_i  = 32'h0000_DEAD;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) $display("FAIL b2b_done got done=%b busy=%b exp 1/0", bus.done_o, bus.busy_o); else n_pass++;
        e = sb.pop_front();
        n_checks++; if ({bus.hi_o, bus.lo_o} !== {e.hi, e.lo}) $display("FAIL b2b_first got %h_%h exp %h_%h", bus.hi_o, bus.lo_o, e.hi, e.lo); else n_pass++;
        expect_op(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1000);
        bus.op_i = OP_MULTU;
        bus.a_i  = 32'hDEAD_BEEF;
        bus.b_i  = 32'h0000_1000;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done();
        n_checks++; if (timeout || lat != 1) $display("FAIL b2b_lat got %0d exp 1", lat); else n_pass++;
        e = sb.pop_front();
        n_checks++; if ({bus.hi_o, bus.lo_o} !== {e.hi, e.lo}) $display("FAIL b2b_second got %h_%h exp %h_%h", bus.hi_o, bus.lo_o, e.hi, e.lo); else n_pass++;
    endtask

    task automatic test_iter_mul();
        logic [2:0]  ops[3];
        logic [15:0] as[3];
        logic [15:0] bs[3];
        logic [31:0] ex[3];
        int          l;
        int          dones;
        ops = '{OP_MULTU, OP_MULT, OP_MULTU};
        as  = '{16'hFFFF, 16'hFFFD, 16'h1234};
        bs  = '{16'hFFFF, 16'h0005, 16'h0100};
        ex  = '{32'hFFFE_0001, 32'hFFFF_FFF1, 32'h0012_3400};
        for (int i = 0; i < 3; i++) begin
            bus2.start_i = 1'b1;
            bus2.op_i    = ops[i];
            bus2.a_i     = as[i];
            bus2.b_i     = bs[i];
            @(posedge clk);
            @(negedge clk);
            bus2.start_i = 1'b0;
            l = 0;
            while (!bus2.done_o && l < 100) begin
                @(posedge clk);
                l++;
                @(negedge clk);
            end
            n_checks++; if (!bus2.done_o || l != 17) $display("FAIL iter_lat[%0d] got %0d exp 17", i, l); else n_pass++;
            n_checks++; if ({bus2.hi_o, bus2.lo_o} !== ex[i]) $display("FAIL iter_hilo[%0d] got %h_%h exp %h", i, bus2.hi_o, bus2.lo_o, ex[i]); else n_pass++;
        end
        bus2.start_i = 1'b1;
        bus2.op_i    = OP_MULTU;
        bus2.a_i     = 16'hABCD;
        bus2.b_i     = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        bus2.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst2 = 1'b1;
        #1;
        n_checks++; if (bus2.hi_o !== 16'h0 || bus2.lo_o !== 16'h0 || bus2.busy_o !== 1'b0) $display("FAIL iter_rst got %h_%h busy=%b exp 0000_0000 busy=0", bus2.hi_o, bus2.lo_o, bus2.busy_o); else n_pass++;
        @(negedge clk);
        rst2  = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus2.done_o) dones++;
        end
        n_checks++; if (dones != 0 || bus2.lo_o !== 16'h0) $display("FAIL iter_rst_dropped got dones=%0d lo=%h exp 0/0000", dones, bus2.lo_o); else n_pass++;
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.annul_i  = 1'b0;
        bus.op_i     = '0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus2.start_i = 1'b0;
        bus2.annul_i = 1'b0;
        bus2.op_i    = '0;
        bus2.a_i     = '0;
        bus2.b_i     = '0;
        test_reset();
        test_mult();
        test_div();
        test_madd_msub();
        test_annul();
        test_back_to_back();
        test_iter_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
